// File: rtl/cpu_test_sequencer_if.sv
// Host-side bundle of the CPU test sequencer: load/dump streams,
// cpu external memory ports, run control and status.
`timescale 1ns/1ps
interface cpu_test_sequencer_if #(
  parameter int IMEM_DATA_W = 32,
  parameter int DMEM_DATA_W = 64,
  parameter int ADDR_W      = 64,
  parameter int CNT_W       = 32
);
  logic                   start;
  logic                   s_valid;
  logic                   s_ready;
  logic [DMEM_DATA_W-1:0] s_data;
  logic [31:0]            cpu_instr;
  logic [DMEM_DATA_W-1:0] rdata_ext_2;
  logic                   enable;
  logic [ADDR_W-1:0]      addr_ext;
  logic                   wen_ext;
  logic                   ren_ext;
  logic [IMEM_DATA_W-1:0] wdata_ext;
  logic [ADDR_W-1:0]      addr_ext_2;
  logic                   wen_ext_2;
  logic                   ren_ext_2;
  logic [DMEM_DATA_W-1:0] wdata_ext_2;
  logic                   m_valid;
  logic                   m_ready;
  logic [DMEM_DATA_W-1:0] m_data;
  logic                   busy;
  logic                   done;
  logic                   timed_out;
  logic [3:0]             test_id;
  logic [CNT_W-1:0]       cycles;

  modport master (
    input  start, s_valid, s_data, cpu_instr,
    input  rdata_ext_2, m_ready,
    output s_ready, enable,
    output addr_ext, wen_ext, ren_ext, wdata_ext,
    output addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2,
    output m_valid, m_data,
    output busy, done, timed_out, test_id, cycles
  );

  modport slave (
    output start, s_valid, s_data, cpu_instr,
    output rdata_ext_2, m_ready,
    input  s_ready, enable,
    input  addr_ext, wen_ext, ren_ext, wdata_ext,
    input  addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2,
    input  m_valid, m_data,
    input  busy, done, timed_out, test_id, cycles
  );
endinterface

// File: rtl/cpu_test_sequencer.sv
// Loads dmem/imem of the cpu from a stream, runs it until STOP or
// timeout, then streams a dmem window back out.
`timescale 1ns/1ps
module cpu_test_sequencer #(
  parameter int         IMEM_DATA_W = 32,
  parameter int         DMEM_DATA_W = 64,
  parameter int         ADDR_W      = 64,
  parameter int         IMEM_WORDS  = 128,
  parameter int         DMEM_WORDS  = 128,
  parameter int         DUMP_BASE   = 35,
  parameter int         DUMP_WORDS  = 12,
  parameter int         TIMEOUT     = 99999,
  parameter logic [6:0] STOP_OPCODE = 7'b1111110,
  parameter int         CNT_W       = 32
) (
  input logic clk,
  input logic arst_n,
  cpu_test_sequencer_if.master bus
);
  localparam int IB = IMEM_DATA_W / 8;
  localparam int DB = DMEM_DATA_W / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_D,
    S_LOAD_I,
    S_RUN,
    S_DUMP_REQ,
    S_DUMP_OUT,
    S_DONE
  } state_t;

  state_t                 r_state;
  logic [31:0]            r_idx;
  logic                   r_en;
  logic [ADDR_W-1:0]      r_addr_i;
  logic                   r_wen_i;
  logic [IMEM_DATA_W-1:0] r_wdata_i;
  logic [ADDR_W-1:0]      r_addr_d;
  logic                   r_wen_d;
  logic                   r_ren_d;
  logic [DMEM_DATA_W-1:0] r_wdata_d;
  logic                   r_mvalid;
  logic [DMEM_DATA_W-1:0] r_mdata;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_to;
  logic [3:0]             r_tid;
  logic [CNT_W-1:0]       r_cycles;

  logic                   w_sready;
  logic [31:0]            w_idx_nxt;
  logic [CNT_W-1:0]       w_cyc_nxt;
  logic                   w_stop;
  logic                   w_tmo;
  logic [31:0]            w_dump_idx;
  logic [ADDR_W-1:0]      w_dump_addr;

  assign w_sready  = (r_state == S_LOAD_D) || (r_state == S_LOAD_I);
  assign w_idx_nxt = r_idx + 32'd1;
  assign w_cyc_nxt = r_cycles + 1'b1;
  assign w_stop    = bus.cpu_instr[6:0] == STOP_OPCODE;
  assign w_tmo     = w_cyc_nxt >= CNT_W'(TIMEOUT);

  // Request address for the word about to be read (first or next).
  assign w_dump_idx  = (r_state == S_RUN) ? r_idx : w_idx_nxt;
  assign w_dump_addr = (ADDR_W'(DUMP_BASE) + ADDR_W'(w_dump_idx))
                     * ADDR_W'(DB);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_en      <= 1'b0;
      r_addr_i  <= '0;
      r_wen_i   <= 1'b0;
      r_wdata_i <= '0;
      r_addr_d  <= '0;
      r_wen_d   <= 1'b0;
      r_ren_d   <= 1'b0;
      r_wdata_d <= '0;
      r_mvalid  <= 1'b0;
      r_mdata   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_to      <= 1'b0;
      r_tid     <= '0;
      r_cycles  <= '0;
    end else begin
      r_wen_i <= 1'b0;
      r_wen_d <= 1'b0;
      r_ren_d <= 1'b0;
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_done   <= 1'b0;
            r_to     <= 1'b0;
            r_cycles <= '0;
            r_tid    <= '0;
            r_idx    <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_LOAD_D;
          end
        end
        S_LOAD_D: begin
          if (bus.s_valid) begin
            r_wen_d   <= 1'b1;
            r_wdata_d <= bus.s_data;
            r_addr_d  <= ADDR_W'(r_idx) * ADDR_W'(DB);
            if (w_idx_nxt == 32'(DMEM_WORDS)) begin
              r_idx   <= '0;
              r_state <= S_LOAD_I;
            end else begin
              r_idx <= w_idx_nxt;
            end
          end
        end
        S_LOAD_I: begin
          if (bus.s_valid) begin
            r_wen_i   <= 1'b1;
            r_wdata_i <= bus.s_data[IMEM_DATA_W-1:0];
            r_addr_i  <= ADDR_W'(r_idx) * ADDR_W'(IB);
            if (w_idx_nxt == 32'(IMEM_WORDS)) begin
              r_idx   <= '0;
              r_state <= S_RUN;
            end else begin
              r_idx <= w_idx_nxt;
            end
          end
        end
        S_RUN: begin
          // First RUN cycle carries the last imem strobe; enable follows.
          if (!r_en) begin
            r_en <= 1'b1;
          end else begin
            r_cycles <= w_cyc_nxt;
            if (w_stop || w_tmo) begin
              r_en  <= 1'b0;
              r_tid <= bus.cpu_instr[31:28];
              r_to  <= w_tmo && !w_stop;
              if (DUMP_WORDS == 0) begin
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= S_DONE;
              end else begin
                r_ren_d  <= 1'b1;
                r_addr_d <= w_dump_addr;
                r_state  <= S_DUMP_REQ;
              end
            end
          end
        end
        S_DUMP_REQ: begin
          r_state <= S_DUMP_OUT;
        end
        S_DUMP_OUT: begin
          if (!r_mvalid) begin
            r_mdata  <= bus.rdata_ext_2;
            r_mvalid <= 1'b1;
          end else if (bus.m_ready) begin
            r_mvalid <= 1'b0;
            if (w_idx_nxt == 32'(DUMP_WORDS)) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_DONE;
            end else begin
              r_idx    <= w_idx_nxt;
              r_ren_d  <= 1'b1;
              r_addr_d <= w_dump_addr;
              r_state  <= S_DUMP_REQ;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.s_ready     = w_sready;
  assign bus.enable      = r_en;
  assign bus.addr_ext    = r_addr_i;
  assign bus.wen_ext     = r_wen_i;
  assign bus.ren_ext     = 1'b0;
  assign bus.wdata_ext   = r_wdata_i;
  assign bus.addr_ext_2  = r_addr_d;
  assign bus.wen_ext_2   = r_wen_d;
  assign bus.ren_ext_2   = r_ren_d;
  assign bus.wdata_ext_2 = r_wdata_d;
  assign bus.m_valid     = r_mvalid;
  assign bus.m_data      = r_mdata;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.timed_out   = r_to;
  assign bus.test_id     = r_tid;
  assign bus.cycles      = r_cycles;
endmodule
